instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch and issue stage for the 4-bit-opcode CPU. It is the producer side of the opcode path.
- Holds the program counter and fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Presents the decoded instruction fields to the control decoder and datapath.
- On instruction completion, computes the next PC from the decoder's M1/M2 select outputs: sequential, branch or jump.

Parameters:
ADDR_W, 16, instruction word-address width; PC arithmetic is modulo 2^ADDR_W
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
run  input  1  enable fetching; 0 parks the unit in IDLE between instructions
imem_req  output  1  instruction memory read request (registered)
imem_addr  output  ADDR_W  word address of the request, equals pc
imem_ack  input  1  memory response valid; imem_data sampled when high
imem_data  input  32  instruction word
pc  output  ADDR_W  address of the instruction being fetched or held
instr_valid  output  1  instruction register holds a live instruction
opcode  output  4  IR[31:28], feeds control decoder
rd  output  4  IR[27:24]
rs  output  4  IR[23:20]
rt  output  4  IR[19:16]
imm  output  16  IR[15:0]
instr_done  input  1  execute stage finished current instruction
M1  input  1  decoder jump select
M2  input  1  decoder PC-redirect select (jump or taken branch)

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, IR=0 (all field outputs 0). An outstanding fetch is abandoned; memory must tolerate a dropped req.
- States:
  - IDLE: imem_req=0, instr_valid=0. If run=1, go to FETCH and set imem_req=1 on the next edge.
  - FETCH: imem_req=1. imem_addr=pc is held stable until ack.
  - ISSUE: imem_req=0, instr_valid=1. IR is frozen.
- FETCH: on a cycle where imem_ack=1:
  - IR<=imem_data, imem_req<=0, instr_valid<=1, state<=ISSUE.
  - Ack in the same cycle req first goes high is legal (zero-wait memory).
- imem_ack while imem_req=0 is ignored; IR is not disturbed.
- run falling during FETCH does not cancel the fetch; it completes into ISSUE. run is only re-examined at instr_done.
- ISSUE: wait for instr_done=1. instr_done outside ISSUE is ignored. In the instr_done cycle, sample M1/M2 (combinational from the decoder on the current opcode and Eq) and update pc:
  - M1=1, M2=1 (jump): pc <= imm[ADDR_W-1:0]. Zero-extend if ADDR_W>16, truncate if smaller.
  - M1=0, M2=1 (taken beq/bne): pc <= pc + 1 + sign_extend(imm), modulo 2^ADDR_W.
  - M2=0: pc <= pc + 1, wrapping from 2^ADDR_W-1 to 0.
  - M1=1, M2=0 (illegal): treated as sequential.
- After instr_done: instr_valid<=0. If run=1, state<=FETCH with imem_req<=1; else state<=IDLE.
- Latency:
  - instr_done at cycle n gives req with the new address at n+1.
  - With zero-wait ack, instr_valid is high again at n+2.
  - Steady-state throughput is therefore at most one instruction per 2 cycles plus execute time.
- Outputs are registered only; no combinational path from imem_ack, M1, M2 or instr_done to any output.

Test Plan:
- Reset then run=1, zero-wait memory, mem[0]=0x4123_0000 (add) -> imem_req high with addr 0 next cycle; opcode=4, rd=1, rs=2, rt=3, instr_valid high one cycle after ack. On instr_done with M2=0 -> pc=1, new req at addr 1.
- Jump: IR imm=0x0040, M1=1, M2=1 at instr_done -> next imem_addr=0x0040.
- Branch backward: pc=0x0010, imm=0xFFFC, M1=0, M2=1 -> next pc=0x000D. Branch forward from pc=0xFFFF, imm=0x0002, ADDR_W=16 -> pc wraps to 0x0002.
- Wait states: ack delayed 3 cycles -> imem_req and imem_addr stable throughout, IR updated only on the ack cycle. Spurious ack in ISSUE -> opcode unchanged.
- run=0 asserted mid-FETCH -> fetch completes, instruction issues. After instr_done -> IDLE, no req. run=1 -> fetch resumes at the updated pc.
- Async rst pulse during FETCH with pc=0x0022 -> imem_req=0, instr_valid=0, pc=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch and issue stage
// Holds the PC, fetches over req/ack, presents IR fields and redirects on completion.
module instr_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [15:0]       imm,
  input  logic              instr_done,
  input  logic              M1,
  input  logic              M2
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] ir;

  logic [ADDR_W-1:0] imm_sx;
  logic [ADDR_W-1:0] imm_zx;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] pc_next;

  assign opcode    = ir[31:28];
  assign rd        = ir[27:24];
  assign rs        = ir[23:20];
  assign rt        = ir[19:16];
  assign imm       = ir[15:0];
  assign imem_addr = pc;

  // Size casts extend (signed/unsigned) or truncate the 16-bit immediate to ADDR_W.
  assign imm_sx = ADDR_W'($signed(ir[15:0]));
  assign imm_zx = ADDR_W'(ir[15:0]);
  assign pc_seq = pc + ADDR_W'(1);

  always_comb begin
    pc_next = pc_seq;
    if (M2) begin
      if (M1) pc_next = imm_zx;
      else    pc_next = pc_seq + imm_sx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      ir          <= '0;
    end else begin
      case (state)
        IDLE: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          // run is deliberately not looked at here; a started fetch always issues.
          if (imem_ack) begin
            ir          <= imem_data;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_done) begin
            pc          <= pc_next;
            instr_valid <= 1'b0;
            if (run) begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [15:0] pc;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [15:0] imm;
  logic        instr_done;
  logic        M1;
  logic        M2;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .pc(pc), .instr_valid(instr_valid),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .instr_done(instr_done), .M1(M1), .M2(M2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ack_with(input logic [31:0] data);
    imem_ack  = 1'b1;
    imem_data = data;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 32'h0;
  endtask

  task automatic retire(input logic m1, input logic m2);
    instr_done = 1'b1;
    M1 = m1;
    M2 = m2;
    @(negedge clk);
    instr_done = 1'b0;
    M1 = 1'b0;
    M2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = 32'h0;
    instr_done = 1'b0; M1 = 1'b0; M2 = 1'b0;
    #2;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // First fetch: zero-wait add at address 0
    run = 1'b1;
    @(negedge clk);
    chk("f0_req", 32'(imem_req), 32'h1);
    chk("f0_addr", 32'(imem_addr), 32'h0);
    ack_with(32'h4123_0000);
    chk("f0_valid", 32'(instr_valid), 32'h1);
    chk("f0_req_low", 32'(imem_req), 32'h0);
    chk("f0_fields", {16'h0, opcode, rd, rs, rt}, 32'h0000_4123);
    chk("f0_imm", 32'(imm), 32'h0);
    retire(1'b0, 1'b0);
    chk("seq_pc", 32'(pc), 32'h1);
    chk("seq_req", 32'(imem_req), 32'h1);
    chk("seq_valid", 32'(instr_valid), 32'h0);

    // Jump to 0x0040
    ack_with(32'hC000_0040);
    chk("jmp_imm", 32'(imm), 32'h0040);
    retire(1'b1, 1'b1);
    chk("jmp_addr", 32'(imem_addr), 32'h0040);
    chk("jmp_req", 32'(imem_req), 32'h1);

    // Backward branch from 0x0010 by -4
    ack_with(32'hC000_0010);
    retire(1'b1, 1'b1);
    chk("jmp10_pc", 32'(pc), 32'h0010);
    ack_with(32'h8000_FFFC);
    retire(1'b0, 1'b1);
    chk("br_back_pc", 32'(pc), 32'h000D);

    // Forward branch wrapping from 0xFFFF
    ack_with(32'hC000_FFFF);
    retire(1'b1, 1'b1);
    chk("jmpffff_pc", 32'(pc), 32'hFFFF);
    ack_with(32'h8000_0002);
    retire(1'b0, 1'b1);
    chk("br_wrap_pc", 32'(pc), 32'h0002);

    // Illegal M1=1,M2=0 behaves as sequential, wrapping 0xFFFF -> 0
    ack_with(32'hC000_FFFF);
    retire(1'b1, 1'b1);
    ack_with(32'h1000_0000);
    retire(1'b1, 1'b0);
    chk("illegal_seq_wrap_pc", 32'(pc), 32'h0000);

    // Three wait states before the ack
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", 32'(imem_req), 32'h1);
      chk("wait_addr", 32'(imem_addr), 32'h0);
      chk("wait_opcode", 32'(opcode), 32'h1);
      chk("wait_valid", 32'(instr_valid), 32'h0);
      @(negedge clk);
    end
    ack_with(32'h5ABC_1234);
    chk("ws_fields", {16'h0, opcode, rd, rs, rt}, 32'h0000_5ABC);
    chk("ws_imm", 32'(imm), 32'h1234);
    ack_with(32'h7FFF_FFFF);
    chk("spur_opcode", 32'(opcode), 32'h5);
    chk("spur_imm", 32'(imm), 32'h1234);
    chk("spur_valid", 32'(instr_valid), 32'h1);

    // run dropped mid-fetch: fetch completes, then unit parks in IDLE
    retire(1'b0, 1'b0);
    chk("r0_pc", 32'(pc), 32'h1);
    run = 1'b0;
    @(negedge clk);
    chk("r0_req_held", 32'(imem_req), 32'h1);
    ack_with(32'h2000_0003);
    chk("r0_valid", 32'(instr_valid), 32'h1);
    chk("r0_opcode", 32'(opcode), 32'h2);
    retire(1'b0, 1'b0);
    chk("idle_req", 32'(imem_req), 32'h0);
    chk("idle_valid", 32'(instr_valid), 32'h0);
    chk("idle_pc", 32'(pc), 32'h2);
    retire(1'b1, 1'b1);
    chk("idle_done_ignored_pc", 32'(pc), 32'h2);
    chk("idle_req2", 32'(imem_req), 32'h0);
    run = 1'b1;
    @(negedge clk);
    chk("resume_req", 32'(imem_req), 32'h1);
    chk("resume_addr", 32'(imem_addr), 32'h2);

    // Async reset mid-fetch at pc=0x0022
    ack_with(32'hC000_0022);
    retire(1'b1, 1'b1);
    chk("pre_rst_pc", 32'(pc), 32'h0022);
    chk("pre_rst_req", 32'(imem_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req), 32'h0);
    chk("arst_valid", 32'(instr_valid), 32'h0);
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_opcode", 32'(opcode), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
